parity_rx_checker: RTL and testbench
====================================

# parity_rx_checker

Serial receive-side parity checker for the parity path driven by the team's XOR parity generator. It deserializes a frame of DATA_W data bits followed by one parity bit, presented one bit per qualified clock. It then presents the assembled word with a one-cycle valid strobe and a parity-error flag. It sits at the far end of the serial link, between the bit-level front end and the word-level consumer.

## Interface
Parameters:
- DATA_W, default 8: data bits per frame, legal range 2..32.
- ODD, default 0: 0 selects even parity (XOR of data and parity bits must be 0); 1 selects odd parity (XOR must be 1).

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- IN_BIT  in  1  serial bit, data LSB first, then the parity bit.
- IN_BIT_VLD  in  1  qualifies IN_BIT and IN_START; the bit is accepted on a rising edge with IN_BIT_VLD=1.
- IN_START  in  1  marks the accepted bit as data bit 0 of a new frame; ignored when IN_BIT_VLD=0.
- OUT_DATA  out  DATA_W  last completed word.
- OUT_VLD  out  1  one-cycle strobe when a frame completes.
- OUT_PERR  out  1  parity error of the last completed frame.
- OUT_BUSY  out  1  a frame is in progress.
- OUT_ABORT  out  1  one-cycle strobe when an in-progress frame is dropped by a new IN_START.
- OUT_ERR_CNT  out  8  saturating parity-error count. Present only when PARITY_ERR_CNT_EN is defined.

## Operation
- The FSM has three states: IDLE, DATA, PARITY.
- IDLE: accepted bits without IN_START are discarded. An accepted bit with IN_START loads bit 0 into the shift register, seeds the running XOR with IN_BIT, sets the bit counter to 1, and moves to DATA.
- DATA: each accepted bit goes to shift register position [count] and XORs into the accumulator; the counter increments. When bit DATA_W-1 is accepted, the FSM moves to PARITY.
- PARITY: the accepted bit is the parity bit. At that edge:
  - OUT_DATA <= shift register.
  - OUT_PERR <= (acc ^ IN_BIT ^ ODD).
  - OUT_VLD <= 1.
  - The FSM returns to IDLE.
- IN_START with IN_BIT_VLD in DATA or PARITY aborts the current frame:
  - no OUT_VLD for the dropped frame;
  - OUT_ABORT pulses;
  - the bit is taken as bit 0 of the new frame and the FSM goes to DATA.
- IN_BIT_VLD=0 stalls: no state, counter, or accumulator change. Stalls have unbounded length.
- OUT_DATA and OUT_PERR hold their values until the next completed frame. An abort does not change them.
- The bit counter is ceil(log2(DATA_W)) bits wide and never wraps within a frame.

## Timing
- Reset values: OUT_DATA=0, OUT_VLD=0, OUT_PERR=0, OUT_BUSY=0, OUT_ABORT=0, OUT_ERR_CNT=0. FSM resets to IDLE.
- Reset mid-frame discards the partial frame, with no strobe.
- Latency: the parity bit is accepted at edge k. OUT_VLD is high for exactly the cycle after edge k, with OUT_DATA and OUT_PERR valid in that same cycle.
- Minimum frame: DATA_W+1 consecutive cycles.
- Back-to-back: IN_START may be accepted on the edge immediately after the parity edge. OUT_VLD of the previous frame and OUT_BUSY of the new frame then coexist.
- OUT_BUSY is registered: 1 from the edge accepting bit 0 through the edge accepting the parity bit, 0 after it.
- OUT_ABORT is high for the one cycle following the aborting edge.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - OUT_ERR_CNT increments on every completed frame with parity error.
  - It saturates at 255 and clears only on reset.
  - Aborted frames are not counted.
- Undefined: the OUT_ERR_CNT port and counter logic are absent. All other behaviour is identical.

## Test plan
- Even parity, DATA_W=8: bits 1,0,1,0,0,1,0,1 (0xA5, START on the first bit), parity 0 -> OUT_VLD one cycle after the parity edge, OUT_DATA=0xA5, OUT_PERR=0. Repeat with parity 1 -> OUT_PERR=1.
- ODD=1: 0x01 with parity 0 -> OUT_PERR=0. 0x01 with parity 1 -> OUT_PERR=1.
- 0x3C frame with IN_BIT_VLD low for 3 cycles after bit 2 and for 5 cycles before the parity bit -> OUT_DATA=0x3C, OUT_PERR correct, OUT_BUSY held high through the stalls.
- Abort: 4 bits of a frame, then START with new frame 0xFF and parity 0 -> OUT_ABORT one cycle, single OUT_VLD with 0xFF, OUT_PERR=0.
- RST_N pulsed low after bit 5 -> all outputs 0 immediately. A following full 0x81 frame decodes correctly.
- With PARITY_ERR_CNT_EN: 300 back-to-back bad-parity frames -> OUT_ERR_CNT=255. Good frames leave the count unchanged.

Source files
------------

// File: rtl/parity_rx_checker_if.sv
// Serial bit-in / word-out bundle between the link front end (master) and the parity checker (slave).
// OUT_ERR_CNT (out_err_cnt) exists only when PARITY_ERR_CNT_EN is defined.
interface parity_rx_checker_if #(
  parameter int DATA_W = 8
);
  logic              in_bit;
  logic              in_bit_vld;
  logic              in_start;
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_perr;
  logic              out_busy;
  logic              out_abort;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]        out_err_cnt;
`endif

  modport master (
    output in_bit, in_bit_vld, in_start,
    input  out_data, out_vld, out_perr, out_busy, out_abort
`ifdef PARITY_ERR_CNT_EN
    , input out_err_cnt
`endif
  );

  modport slave (
    input  in_bit, in_bit_vld, in_start,
    output out_data, out_vld, out_perr, out_busy, out_abort
`ifdef PARITY_ERR_CNT_EN
    , output out_err_cnt
`endif
  );
endinterface

// File: rtl/parity_rx_checker.sv
// Serial receive parity checker: LSB-first data bits then a parity bit, presented as a word with a
// one-cycle valid strobe. Optional saturating error counter enabled by macro PARITY_ERR_CNT_EN.
module parity_rx_checker #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input logic             i_clk,
  input logic             i_rst_n,
  parity_rx_checker_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_acc;
  logic [DATA_W-1:0] r_data;
  logic              r_vld;
  logic              r_perr;
  logic              r_abort;
  logic              w_perr;

  assign w_perr = r_acc ^ bus.in_bit ^ ODD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= 1'b0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_perr  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_vld   <= 1'b0;
      r_abort <= 1'b0;
      if (bus.in_bit_vld) begin
        if (bus.in_start) begin
          // A start always begins a new frame; any frame in flight is dropped silently except for the abort strobe.
          r_abort <= (r_state != ST_IDLE);
          r_shift <= {{(DATA_W-1){1'b0}}, bus.in_bit};
          r_acc   <= bus.in_bit;
          r_cnt   <= CNT_W'(1);
          r_state <= ST_DATA;
        end else begin
          case (r_state)
            ST_DATA: begin
              r_shift[r_cnt] <= bus.in_bit;
              r_acc          <= r_acc ^ bus.in_bit;
              if (r_cnt == LAST_IDX) begin
                r_state <= ST_PARITY;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            ST_PARITY: begin
              r_data  <= r_shift;
              r_perr  <= w_perr;
              r_vld   <= 1'b1;
              r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.in_bit_vld && !bus.in_start && (r_state == ST_PARITY)
                 && w_perr && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.out_err_cnt = r_err_cnt;
`endif

  assign bus.out_data  = r_data;
  assign bus.out_vld   = r_vld;
  assign bus.out_perr  = r_perr;
  assign bus.out_busy  = (r_state != ST_IDLE);
  assign bus.out_abort = r_abort;
endmodule

// File: tb/tb_parity_rx_checker.sv
// Scoreboard bench: one even-parity and one odd-parity checker share the same serial stimulus.
module tb_parity_rx_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_bit = 1'b0;
  logic d_vld = 1'b0;
  logic d_start = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_abort_e = 0, n_abort_o = 0, exp_abort = 0;
  int exp_cnt_e = 0, exp_cnt_o = 0;

  typedef struct packed { logic [7:0] data; logic perr; } exp_t;
  exp_t q_e[$];
  exp_t q_o[$];

  parity_rx_checker_if #(.DATA_W(8)) ifc_e();
  parity_rx_checker_if #(.DATA_W(8)) ifc_o();

  assign ifc_e.in_bit = d_bit;  assign ifc_e.in_bit_vld = d_vld;  assign ifc_e.in_start = d_start;
  assign ifc_o.in_bit = d_bit;  assign ifc_o.in_bit_vld = d_vld;  assign ifc_o.in_start = d_start;

  parity_rx_checker #(.DATA_W(8), .ODD(1'b0)) u_even (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc_e));
  parity_rx_checker #(.DATA_W(8), .ODD(1'b1)) u_odd  (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifc_e.out_vld) begin
      if (q_e.size() == 0) check("unexpected_vld_even", 1, 0);
      else begin
        e = q_e.pop_front();
        check("data_even", ifc_e.out_data, e.data);
        check("perr_even", ifc_e.out_perr, e.perr);
        $display("even frame data=0x%02h perr=%0d", ifc_e.out_data, ifc_e.out_perr);
      end
    end
    if (ifc_o.out_vld) begin
      if (q_o.size() == 0) check("unexpected_vld_odd", 1, 0);
      else begin
        e = q_o.pop_front();
        check("data_odd", ifc_o.out_data, e.data);
        check("perr_odd", ifc_o.out_perr, e.perr);
        $display("odd  frame data=0x%02h perr=%0d", ifc_o.out_data, ifc_o.out_perr);
      end
    end
    if (ifc_e.out_abort) n_abort_e++;
    if (ifc_o.out_abort) n_abort_o++;
  end

  task automatic put(input logic b, input logic s);
    d_vld = 1'b1; d_bit = b; d_start = s;
    @(posedge clk); #1;
    d_vld = 1'b0; d_start = 1'b0;
  endtask

  task automatic stall(input int n, input logic chk_busy);
    for (int i = 0; i < n; i++) begin
      d_bit = ~d_bit;  // must be ignored while not qualified
      @(posedge clk); #1;
      if (chk_busy) check("busy_in_stall", ifc_e.out_busy, 1);
    end
  endtask

  task automatic push_exp(input logic [7:0] data, input logic p);
    logic pe, po;
    pe = ^data ^ p;
    po = ^data ^ p ^ 1'b1;
    q_e.push_back('{data: data, perr: pe});
    q_o.push_back('{data: data, perr: po});
    if (pe && exp_cnt_e < 255) exp_cnt_e++;
    if (po && exp_cnt_o < 255) exp_cnt_o++;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic p, input int st2, input int stp);
    for (int i = 0; i < 8; i++) begin
      put(data[i], i == 0);
      if (i == 0) check("busy_after_start", ifc_e.out_busy, 1);
      if (i == 2) stall(st2, 1'b1);
    end
    stall(stp, 1'b1);
    check("vld_before_parity", ifc_e.out_vld, 0);
    push_exp(data, p);
    put(p, 1'b0);
    check("vld_latency", ifc_e.out_vld, 1);
    check("busy_after_parity", ifc_e.out_busy, 0);
  endtask

  initial begin
    logic [7:0] rd;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", ifc_e.out_data, 0);
    check("rst_vld", ifc_e.out_vld, 0);
    check("rst_perr", ifc_e.out_perr, 0);
    check("rst_busy", ifc_e.out_busy, 0);
    check("rst_abort", ifc_e.out_abort, 0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt", ifc_e.out_err_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // bits without START in idle are discarded
    put(1'b1, 1'b0); put(1'b0, 1'b0);
    check("idle_discard_busy", ifc_e.out_busy, 0);

    send_frame(8'hA5, 1'b0, 0, 0);
    send_frame(8'hA5, 1'b1, 0, 0);
    send_frame(8'h01, 1'b0, 0, 0);
    send_frame(8'h01, 1'b1, 0, 0);
    send_frame(8'h3C, 1'b0, 3, 5);
    stall(2, 1'b0);

    // abort after 4 bits of a frame, then a full 0xFF frame
    put(1'b1, 1'b1); put(1'b0, 1'b0); put(1'b1, 1'b0); put(1'b0, 1'b0);
    exp_abort++;
    send_frame(8'hFF, 1'b0, 0, 0);
    stall(2, 1'b0);
    check("abort_cnt_even", n_abort_e, exp_abort);

    // reset after bit 5 of a frame
    for (int i = 0; i < 6; i++) put(1'b1, i == 0);
    rst_n = 1'b0;
    #1;
    check("midrst_data", ifc_e.out_data, 0);
    check("midrst_perr", ifc_e.out_perr, 0);
    check("midrst_busy", ifc_e.out_busy, 0);
    check("midrst_vld", ifc_e.out_vld, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt_e = 0; exp_cnt_o = 0;
    send_frame(8'h81, 1'b0, 0, 0);

    // back-to-back and randomised frames with random stalls
    for (int k = 0; k < 20; k++) begin
      rd = 8'($urandom);
      send_frame(rd, 1'($urandom), (k % 3 == 0) ? $urandom_range(0, 3) : 0,
                 (k % 4 == 1) ? $urandom_range(0, 4) : 0);
    end
    stall(2, 1'b0);

`ifdef PARITY_ERR_CNT_EN
    check("err_cnt_even", ifc_e.out_err_cnt, exp_cnt_e);
    check("err_cnt_odd", ifc_o.out_err_cnt, exp_cnt_o);
    for (int k = 0; k < 300; k++) begin
      rd = 8'($urandom);
      send_frame(rd, ~(^rd), 0, 0);
    end
    stall(2, 1'b0);
    check("err_cnt_sat", ifc_e.out_err_cnt, 255);
    send_frame(8'h5A, 1'b0, 0, 0);
    stall(2, 1'b0);
    check("err_cnt_hold", ifc_e.out_err_cnt, 255);
    check("err_cnt_odd_end", ifc_o.out_err_cnt, exp_cnt_o);
`endif

    check("abort_total_even", n_abort_e, exp_abort);
    check("abort_total_odd", n_abort_o, exp_abort);
    check("pending_even", q_e.size(), 0);
    check("pending_odd", q_o.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
